i2c_codec_slave: RTL
====================

Name: i2c_codec_slave

Overview:
- I2C write-only target that emulates the audio codec's control port: receives 3-byte frames [slave addr, {reg[6:0],data[8]}, data[7:0]] and stores 9-bit values in a 16-entry register file.
- Sits on the board I2C bus, or on the bench opposite the codec configuration master, so that configuration sequences can be checked end-to-end.
- Oversamples SCL/SDA on the system clock.
- Drives SDA open-drain through an output-enable only.

Parameters:
- SLAVE_ADDR, 7'h1A, 7-bit target address (write byte 8'h34).
- NUM_REGS, 16, register-file depth; reg indices >= NUM_REGS are ACKed but discarded.
- RESET_REG, 7'h0F, register index whose write clears the whole register file.

Ports:
- iCLK  in  1  system clock; SCL must be at most iCLK/16.
- iRST  in  1  synchronous reset, active-high.
- iSCL  in  1  I2C clock, asynchronous.
- iSDA  in  1  I2C data line, resolved value, asynchronous.
- oSDA_OE  out  1  1 = pull SDA low (ACK); 0 = release.
- oWR_STB  out  1  one-cycle pulse when a word is committed.
- oWR_ADDR  out  7  register index of the last committed word.
- oWR_DATA  out  9  data of the last committed word.
- iRD_ADDR  in  4  register-file readback index (combinational read).
- oRD_DATA  out  9  contents of regfile[iRD_ADDR].
- oBUSY  out  1  high from START to STOP.
- oNACK_CNT  out  8  saturating count of address bytes not ACKed.

Behaviour:
- Reset: oSDA_OE=0, oWR_STB=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0, oNACK_CNT=0, all registers = 0, state IDLE.
- Synchronization: iSCL and iSDA each pass through 2 flops, then a 1-flop history for edge detection. Events occur 3 cycles after the pin change.
- Bus events:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on an SCL rising edge, MSB first.
- States:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits. After the 8th rising edge:
    - addr == SLAVE_ADDR and R/W = 0 -> ADDR_ACK.
    - otherwise -> IGNORE, and oNACK_CNT += 1 (saturates at 255).
  - ADDR_ACK, ACK1, ACK2: on the SCL falling edge that follows the 8th bit, set oSDA_OE = 1. On the next SCL falling edge, set oSDA_OE = 0 and move on:
    - ADDR_ACK -> BYTE1
    - ACK1 -> BYTE2
    - ACK2 -> BYTE1, so a master may stream further word pairs without STOP.
  - BYTE1: latch {reg[6:0], d8} -> ACK1.
  - BYTE2: latch d[7:0] -> ACK2. The commit happens at the 8th rising edge.
  - IGNORE: oSDA_OE held 0; wait for STOP or START.
- Commit, in the cycle after the 8th bit of byte 2 is sampled:
  - oWR_STB = 1 for 1 cycle; oWR_ADDR and oWR_DATA update.
  - reg < NUM_REGS: regfile[reg] <= data.
  - reg == RESET_REG: all entries <= 0. oWR_STB still pulses and RESET_REG is not stored. RESET_REG takes priority over the NUM_REGS range check.
  - reg >= NUM_REGS otherwise: no store, no strobe; the byte is still ACKed.
- Boundary conditions:
  - STOP in any state -> IDLE, oSDA_OE = 0; a partial word is discarded with no strobe.
  - START (repeated) in any state -> ADDR, bit counter cleared, partial word discarded.
  - START/STOP detection has priority over bit sampling in the same cycle.
  - oBUSY = 1 from START until STOP, including while in IGNORE.
  - iRST asserted mid-frame -> full reset. SDA is released the next cycle, and the module waits for a new START (no resync on data bits).
  - SDA is never driven except during the ACK slot.

Decomposition:
- Package i2c_codec_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE);
  - codec register index constants: LIN_L=0, LIN_R=1, HEAD_L=2, HEAD_R=3, A_PATH=4, D_PATH=5, POWER=6, FORMAT=7, SAMPLE=8, ACTIVE=9, RESET=15;
  - the default SLAVE_ADDR.
- Sub-module i2c_line_sync contains the 2-flop synchronizers and the SCL rise/fall and START/STOP detectors. Outputs are single-cycle pulses plus the synchronized SDA.

Test Plan:
- Write frame 8'h34,8'h00,8'h1A at SCL = iCLK/50 -> ACK on all 3 bytes; one oWR_STB with oWR_ADDR=0, oWR_DATA=9'h01A; iRD_ADDR=0 reads 9'h01A.
- Frame 8'h34,8'h05,8'hFF -> reg 2 = 9'h1FF. Then 8'h34,8'h1E,8'h00 -> strobe with addr 15, and regs 0..15 all read 0.
- Frame to 8'h36 -> no ACK (SDA stays high at the 9th clock), no strobe, oNACK_CNT=1. A following valid frame to 8'h34 still succeeds.
- 8'h34,8'h02 then STOP -> no strobe, reg 1 unchanged. Repeated START then 8'h34,8'h02,8'h1A -> reg 1 = 9'h01A.
- Streamed 8'h34,8'h08,8'hF8,8'h0A,8'h06 in one frame -> two strobes: reg 4 = 9'h0F8, reg 5 = 9'h006.
- Pulse iRST during byte 2 -> oSDA_OE=0 and oBUSY=0 next cycle, no strobe, all regs 0; the next complete frame is accepted.

Source files
------------

// File: rtl/i2c_codec_pkg.sv
// ----------------------------------------------------------------------------
// i2c_codec_pkg
// Shared types and constants for the I2C codec control-port target.
//   stateT              : protocol FSM states
//   LIN_L .. RESET      : codec register indices
//   DEFAULT_SLAVE_ADDR  : 7-bit target address (write byte 8'h34)
//   isAckState()        : true for the three ACK-slot states
// ----------------------------------------------------------------------------
package i2c_codec_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      BYTE1,
      ACK1,
      BYTE2,
      ACK2,
      IGNORE
   } stateT;

   localparam logic [6:0] LIN_L  = 7'd0;
   localparam logic [6:0] LIN_R  = 7'd1;
   localparam logic [6:0] HEAD_L = 7'd2;
   localparam logic [6:0] HEAD_R = 7'd3;
   localparam logic [6:0] A_PATH = 7'd4;
   localparam logic [6:0] D_PATH = 7'd5;
   localparam logic [6:0] POWER  = 7'd6;
   localparam logic [6:0] FORMAT = 7'd7;
   localparam logic [6:0] SAMPLE = 7'd8;
   localparam logic [6:0] ACTIVE = 7'd9;
   localparam logic [6:0] RESET  = 7'd15;

   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h1A;

   function automatic logic isAckState(input stateT s);
      return (s == ADDR_ACK) || (s == ACK1) || (s == ACK2);
   endfunction

endpackage

// File: rtl/i2c_codec_slave_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA pins into the iCLK domain and decodes bus
// events as single-cycle pulses.
//   iCLK, iRST : system clock, synchronous active-high reset
//   iSCL, iSDA : raw bus lines
//   oSclRise   : SCL rising edge
//   oSclFall   : SCL falling edge
//   oStart     : SDA falling while SCL high
//   oStop      : SDA rising while SCL high
//   oSda       : synchronized SDA level
// ----------------------------------------------------------------------------
module i2c_line_sync (
   input  logic iCLK,
   input  logic iRST,
   input  logic iSCL,
   input  logic iSDA,
   output logic oSclRise,
   output logic oSclFall,
   output logic oStart,
   output logic oStop,
   output logic oSda
);

   logic sclMeta, sclSync, sclHist;
   logic sdaMeta, sdaSync, sdaHist;

   // The synchronizer chain keeps tracking the pins through reset, so that on
   // release it already holds the true line levels and cannot report a false
   // START/STOP edge. iRST is intentionally unused here.
   // NOTE: sequential state uses non-blocking assignments so every flop in the
   // chain samples the pre-edge value of its predecessor.
   always_ff @(posedge iCLK) begin
      sclMeta <= iSCL;
      sclSync <= sclMeta;
      sclHist <= sclSync;
      sdaMeta <= iSDA;
      sdaSync <= sdaMeta;
      sdaHist <= sdaSync;
   end

   logic unusedRst;
   assign unusedRst = iRST;

   assign oSclRise = sclSync & ~sclHist;
   assign oSclFall = ~sclSync & sclHist;
   assign oStart   = sclSync & sclHist & sdaHist & ~sdaSync;
   assign oStop    = sclSync & sclHist & ~sdaHist & sdaSync;
   assign oSda     = sdaSync;

endmodule

// File: rtl/i2c_codec_slave.sv
// ----------------------------------------------------------------------------
// i2c_codec_slave
// Write-only I2C target emulating an audio codec control port. Frames are
// [addr+W, {reg[6:0],d8}, d[7:0]] and may stream further word pairs before
// STOP. Committed words land in a NUM_REGS x 9-bit register file.
//   iCLK, iRST  : system clock, synchronous active-high reset
//   iSCL, iSDA  : I2C bus lines (asynchronous)
//   oSDA_OE     : 1 = pull SDA low (ACK slot only)
//   oWR_STB     : one-cycle pulse per committed word
//   oWR_ADDR    : register index of last committed word
//   oWR_DATA    : data of last committed word
//   iRD_ADDR    : readback index
//   oRD_DATA    : regFile[iRD_ADDR] (combinational)
//   oBUSY       : high from START to STOP
//   oNACK_CNT   : saturating count of address bytes not ACKed
// ----------------------------------------------------------------------------
module i2c_codec_slave
   import i2c_codec_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
   parameter int         NUM_REGS   = 16,
   parameter logic [6:0] RESET_REG  = RESET
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iSCL,
   input  logic       iSDA,
   output logic       oSDA_OE,
   output logic       oWR_STB,
   output logic [6:0] oWR_ADDR,
   output logic [8:0] oWR_DATA,
   input  logic [3:0] iRD_ADDR,
   output logic [8:0] oRD_DATA,
   output logic       oBUSY,
   output logic [7:0] oNACK_CNT
);

   localparam int IDX_W = $clog2(NUM_REGS);

   logic sclRise, sclFall, busStart, busStop, sdaSync;

   i2c_line_sync uLineSync (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iSCL     (iSCL),
      .iSDA     (iSDA),
      .oSclRise (sclRise),
      .oSclFall (sclFall),
      .oStart   (busStart),
      .oStop    (busStop),
      .oSda     (sdaSync)
   );

   stateT       state, stateNext;
   logic [2:0]  bitCnt;
   logic [6:0]  shiftReg;
   logic [7:0]  byte1;
   logic        ackPhase;   // 0: before ACK drive, 1: SDA held low
   logic        busy;
   logic [8:0]  regFile [NUM_REGS];

   logic        byteDone;
   logic [7:0]  byteIn;
   logic [6:0]  regIdx;
   logic [8:0]  wordData;
   logic        addrOk;

   assign byteDone = sclRise && (bitCnt == 3'd7);
   assign byteIn   = {shiftReg, sdaSync};
   assign regIdx   = byte1[7:1];
   assign wordData = {byte1[0], byteIn};
   assign addrOk   = (byteIn == {SLAVE_ADDR, 1'b0});

   // State register
   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else      state <= stateNext;
   end

   // Next-state logic; bus conditions override bit handling.
   // NOTE: the default assignment at the top of a combinational block keeps
   // every path assigned, so no latch is inferred.
   always_comb begin
      stateNext = state;
      if (busStart) begin
         stateNext = ADDR;
      end else if (busStop) begin
         stateNext = IDLE;
      end else begin
         case (state)
            ADDR:     if (byteDone) stateNext = addrOk ? ADDR_ACK : IGNORE;
            BYTE1:    if (byteDone) stateNext = ACK1;
            BYTE2:    if (byteDone) stateNext = ACK2;
            ADDR_ACK: if (sclFall && ackPhase) stateNext = BYTE1;
            ACK1:     if (sclFall && ackPhase) stateNext = BYTE2;
            ACK2:     if (sclFall && ackPhase) stateNext = BYTE1;
            default:  stateNext = state;
         endcase
      end
   end

   // Outputs: SDA is only ever pulled inside an ACK slot.
   always_comb begin
      oSDA_OE  = ackPhase && isAckState(state);
      oBUSY    = busy;
      oRD_DATA = regFile[iRD_ADDR];
   end

   // Datapath: shifting, ACK phase, commit, counters.
   // NOTE: the register file is cleared by reset like any other state because
   // the codec's registers power up to zero and software reads them back.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         bitCnt    <= '0;
         shiftReg  <= '0;
         byte1     <= '0;
         ackPhase  <= 1'b0;
         busy      <= 1'b0;
         oNACK_CNT <= '0;
         oWR_STB   <= 1'b0;
         oWR_ADDR  <= '0;
         oWR_DATA  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
      end else begin
         oWR_STB <= 1'b0;
         if (busStart || busStop) begin
            // Any partial word is simply abandoned.
            bitCnt   <= '0;
            ackPhase <= 1'b0;
            busy     <= busStart;
         end else begin
            case (state)
               ADDR, BYTE1, BYTE2: begin
                  if (sclRise) begin
                     shiftReg <= byteIn[6:0];
                     bitCnt   <= bitCnt + 3'd1;   // wraps to 0 after bit 8
                  end
                  if (byteDone) begin
                     if (state == ADDR && !addrOk && oNACK_CNT != 8'hFF)
                        oNACK_CNT <= oNACK_CNT + 8'd1;
                     if (state == BYTE1)
                        byte1 <= byteIn;
                     if (state == BYTE2) begin
                        // RESET_REG is checked before the range test.
                        if (regIdx == RESET_REG) begin
                           for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
                           oWR_STB  <= 1'b1;
                           oWR_ADDR <= regIdx;
                           oWR_DATA <= wordData;
                        end else if (int'(regIdx) < NUM_REGS) begin
                           regFile[regIdx[IDX_W-1:0]] <= wordData;
                           oWR_STB  <= 1'b1;
                           oWR_ADDR <= regIdx;
                           oWR_DATA <= wordData;
                        end
                     end
                  end
               end
               ADDR_ACK, ACK1, ACK2: begin
                  if (sclFall) ackPhase <= ~ackPhase;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
